float_to_int_pipe: RTL and testbench
====================================

# float_to_int_pipe

Pipelined IEEE-754 single-precision to 32-bit two's-complement integer converter: the reverse direction of the integer-to-float converter in the floating point module. It sits behind the FPU register read path for cvt.w.s-style operations and accepts one float per cycle through a valid/ready handshake. It truncates toward zero and reports precision loss and invalid conversions.

## Interface
- No parameters; widths are fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge
- clrn  in  1  reset, synchronous, active-low
- in_valid  in  1  a holds a float to convert
- in_ready  out  1  block can accept a this cycle
- a  in  32  float operand {sign, exp[7:0], frac[22:0]}
- out_valid  out  1  d/p_lost/invalid are valid
- out_ready  in  1  consumer takes the result this cycle
- d  out  32  integer result
- p_lost  out  1  nonzero fraction bits were discarded
- invalid  out  1  NaN, Inf or out of int32 range

## Operation
- Classification, with e = a[30:23], m = {1, a[22:0]}, sh = e - 127:
  - a[30:0] == 0: d = 0, p_lost = 0, invalid = 0. This covers ±0.
  - e < 127: |x| < 1, including denormals. d = 0, p_lost = 1, invalid = 0.
  - a == 32'hCF000000 (exactly -2^31): d = 32'h80000000, no flags.
  - e >= 158, including e == 255 (Inf/NaN): d = 32'h80000000, invalid = 1, p_lost = 0.
  - Otherwise sh is in 0..30:
    - If sh >= 23: mag = m << (sh - 23), p_lost = 0.
    - Else: mag = m >> (23 - sh), p_lost = OR of the 23 - sh shifted-out bits.
    - d = sign ? -mag : mag. Because mag < 2^31, the negation never overflows.
- Rounding is truncation toward zero only.
- Results leave the block in acceptance order. No reordering, no drops.

## Timing
- The pipeline has 3 register stages:
  - S1: classify; register sign, class, m, sh.
  - S2: shift; register mag and lost.
  - S3: negate and select; register d, p_lost, invalid.
- Global advance enable: en = ~out_valid | out_ready. Every stage register, including its valid bit, loads only when en = 1.
- in_ready = en, combinational from out_valid and out_ready.
- A transfer occurs on in_valid & in_ready. Its result appears with out_valid = 1 exactly 3 cycles later when out_ready is held high.
- Throughput is 1 per cycle. A bubble (in_valid = 0 while en = 1) propagates as valid = 0.
- When out_valid = 1 and out_ready = 0, every stage freezes, in_ready = 0, and d, p_lost and invalid hold stable.
- Reset (clrn = 0 at a clock edge) clears all stage valid bits and out_valid, and sets d = 0, p_lost = 0, invalid = 0. In-flight operands are discarded.
- in_ready = 1 in the first cycle after reset is released.
- Reset overrides any simultaneous transfer.
- Output data is don't-care while out_valid = 0 but must not contain X after reset.

## Structure
- Shared package (fp_pkg): BIAS = 127, EXP_MAX_INT = 158, INT_MIN = 32'h80000000, NEG_2_31 = 32'hCF000000, and a 3-bit class enum {ZERO, SMALL, NORMAL, INVALID, EXACT_MIN}.
- Sub-module f2i_shift: combinational 24-bit to 32-bit bidirectional barrel shifter with a sticky OR of shifted-out bits. It is instantiated once in stage S2.
- Top level contains the classifier, the three stage registers, the enable logic and the S3 negate/select.

## Test plan
- Basic values, out_ready held high:
  - 32'h40490FDB (3.14159) -> d = 3, p_lost = 1, invalid = 0; out_valid rises exactly 3 cycles after acceptance.
  - 32'hC1200000 (-10.0) -> d = 32'hFFFFFFF6, no flags.
- Range limits:
  - 32'h4F000000 (2^31) -> d = 32'h80000000, invalid = 1.
  - 32'hCF000000 -> d = 32'h80000000, invalid = 0.
  - 32'h7FC00000 (NaN) -> d = 32'h80000000, invalid = 1.
  - 32'h4EFFFFFF -> d = 32'h7FFFFF80, no flags.
- Small and zero inputs:
  - 32'h3F000000 (0.5) -> d = 0, p_lost = 1.
  - 32'h00000001 (denormal) -> d = 0, p_lost = 1.
  - 32'h80000000 (-0) -> d = 0, no flags.
- Round trip: 32'h4B7FFFFF (the converter's encoding of 16777215) -> d = 32'h00FFFFFF, p_lost = 0.
- Backpressure: issue 6 back-to-back operands, then drop out_ready for 4 cycles mid-stream.
  - in_ready is low during the stall.
  - d holds stable.
  - All 6 results emerge in order with none lost or duplicated.
- Reset: assert clrn = 0 for one cycle while 3 results are in flight.
  - out_valid = 0, d = 0, flags 0 on the next cycle.
  - No stale result appears afterward.
  - A fresh operand yields out_valid 3 cycles after acceptance.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, types and classification helper for the float-to-int
// conversion path.
package fp_pkg;

  localparam int          FRAC_W      = 23;
  localparam int          MAN_W       = 24;
  localparam int          BIAS        = 127;
  localparam int          EXP_MAX_INT = 158;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;
  localparam logic [31:0] NEG_2_31    = 32'hCF00_0000;

  // Conversion class decided once in S1 and carried down the pipe.
  typedef enum logic [2:0] {
    ZERO,
    SMALL,
    NORMAL,
    INVALID,
    EXACT_MIN
  } f2i_class_e;

  // S1 -> S2 payload.
  typedef struct packed {
    logic              sign;
    f2i_class_e        cls;
    logic [MAN_W-1:0]  m;
    logic [4:0]        sh;
  } s1_t;

  // S2 -> S3 payload.
  typedef struct packed {
    logic        sign;
    f2i_class_e  cls;
    logic [31:0] mag;
    logic        lost;
  } s2_t;

  // Final registered result.
  typedef struct packed {
    logic [31:0] d;
    logic        p_lost;
    logic        invalid;
  } res_t;

  // Order matters: exactly -2^31 shares the out-of-range exponent, so it is
  // recognised before the generic invalid test.
  function automatic f2i_class_e classify(input logic [31:0] f);
    logic [7:0] e;
    e = f[30:23];
    if (f[30:0] == 31'd0)                 return ZERO;
    else if (e < 8'(BIAS))                return SMALL;
    else if (f == NEG_2_31)               return EXACT_MIN;
    else if (e >= 8'(EXP_MAX_INT))        return INVALID;
    else                                  return NORMAL;
  endfunction

endpackage

// File: rtl/f2i_shift.sv
// Combinational bidirectional barrel shifter: places the 24-bit mantissa so
// that its binary point lands at bit 0, and reports whether any discarded
// fraction bit was set.
module f2i_shift
  import fp_pkg::*;
(
  input  logic [MAN_W-1:0] m_i,
  input  logic [4:0]       sh_i,     // unbiased exponent, 0..30
  output logic [31:0]      mag_o,
  output logic             sticky_o
);

  logic [31:0]      ext;
  logic [4:0]       amt;
  logic [MAN_W-1:0] mask;

  // Left shift for large exponents, right shift with sticky otherwise.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else can leave a value held, which would infer a latch.
    ext      = {8'd0, m_i};
    amt      = '0;
    mask     = '0;
    mag_o    = '0;
    sticky_o = 1'b0;
    if (sh_i >= 5'(FRAC_W)) begin
      amt   = sh_i - 5'(FRAC_W);
      mag_o = ext << amt;
    end else begin
      amt      = 5'(FRAC_W) - sh_i;
      mag_o    = ext >> amt;
      mask     = (24'h1 << amt) - 24'h1;
      sticky_o = |(m_i & mask);
    end
  end

endmodule

// File: rtl/float_to_int_pipe.sv
// Three-stage IEEE-754 single to int32 converter with truncation toward zero.
// S1 classifies, S2 aligns the mantissa, S3 negates and selects the result.
// A single advance enable freezes the whole pipe under output backpressure.
module float_to_int_pipe
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        p_lost,
  output logic        invalid
);

  logic en;

  logic  s1_v_q, s2_v_q, s3_v_q;
  s1_t   s1_d, s1_q;
  s2_t   s2_d, s2_q;
  res_t  res_d, res_q;

  logic [7:0]  unb_exp;
  logic [31:0] shf_mag;
  logic        shf_sticky;

  // The pipe moves whenever the output slot is empty or being drained.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // ---------------- S1: classify ----------------
  assign unb_exp = a[30:23] - 8'(BIAS);

  // Build the S1 payload; mantissa and shift only matter for NORMAL inputs.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = a[31];
    s1_d.cls  = classify(a);
    if (s1_d.cls == NORMAL) begin
      s1_d.m  = {1'b1, a[FRAC_W-1:0]};
      s1_d.sh = unb_exp[4:0];
    end
  end

  // S1 register stage.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage samples
    // the previous stage's old value on the same edge.
    // NOTE: the datapath registers are reset as well, not only the valid bits,
    // so bubbles flowing to the output never carry X after reset.
    if (!clrn) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
    end else if (en) begin
      s1_v_q <= in_valid;
      s1_q   <= s1_d;
    end
  end

  // ---------------- S2: align ----------------
  f2i_shift u_shift (
    .m_i      (s1_q.m),
    .sh_i     (s1_q.sh),
    .mag_o    (shf_mag),
    .sticky_o (shf_sticky)
  );

  // Forward sign/class and capture the aligned magnitude.
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.cls  = s1_q.cls;
    if (s1_q.cls == NORMAL) begin
      s2_d.mag  = shf_mag;
      s2_d.lost = shf_sticky;
    end
  end

  // S2 register stage.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      s2_v_q <= 1'b0;
      s2_q   <= '0;
    end else if (en) begin
      s2_v_q <= s1_v_q;
      s2_q   <= s2_d;
    end
  end

  // ---------------- S3: negate and select ----------------
  // Magnitude is below 2^31 for NORMAL, so two's-complement negation is exact.
  always_comb begin
    res_d = '0;
    case (s2_q.cls)
      ZERO:      res_d = '0;
      SMALL:     res_d.p_lost = 1'b1;
      EXACT_MIN: res_d.d = INT_MIN;
      INVALID: begin
        res_d.d       = INT_MIN;
        res_d.invalid = 1'b1;
      end
      NORMAL: begin
        res_d.d      = s2_q.sign ? (~s2_q.mag + 32'd1) : s2_q.mag;
        res_d.p_lost = s2_q.lost;
      end
      default:   res_d = '0;
    endcase
  end

  // S3 register stage, which is also the output register.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      s3_v_q <= 1'b0;
      res_q  <= '0;
    end else if (en) begin
      s3_v_q <= s2_v_q;
      res_q  <= res_d;
    end
  end

  assign out_valid = s3_v_q;
  assign d         = res_q.d;
  assign p_lost    = res_q.p_lost;
  assign invalid   = res_q.invalid;

endmodule

// File: tb/tb_float_to_int_pipe.sv
// Self-checking bench for float_to_int_pipe: arithmetic reference model plus
// scoreboard, directed vectors, backpressure and mid-stream reset.
module tb_float_to_int_pipe;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] d;
  logic        p_lost;
  logic        invalid;

  float_to_int_pipe dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .p_lost    (p_lost),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        p;
    logic        inv;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        p;
    logic        inv;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: value = m * 2^(e-150), truncated toward zero.
  function automatic exp_t model(input logic [31:0] x);
    exp_t   r;
    int     e;
    longint m, mag, div;
    r   = '0;
    e   = int'(x[30:23]);
    m   = longint'({1'b1, x[22:0]});
    mag = 0;
    if (x[30:0] == 31'd0) begin
      r = '0;
    end else if (e < 127) begin
      r.p = 1'b1;
    end else if (x == 32'hCF00_0000) begin
      r.d = 32'h8000_0000;
    end else if (e >= 158) begin
      r.d   = 32'h8000_0000;
      r.inv = 1'b1;
    end else begin
      if (e - 127 >= 23) begin
        mag = m * (longint'(1) << (e - 150));
      end else begin
        div = longint'(1) << (150 - e);
        mag = m / div;
        r.p = (m % div) != 0;
      end
      r.d = x[31] ? 32'(-mag) : 32'(mag);
    end
    return r;
  endfunction

  // Scoreboard: record accepted operands, compare every delivered result.
  always @(negedge clk) begin
    exp_t e;
    if (!clrn) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("stray_result", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_d", d, e.d);
          check("sb_p_lost", 32'(p_lost), 32'(e.p));
          check("sb_invalid", 32'(invalid), 32'(e.inv));
          n_out++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(a));
    end
  end

  // Present one operand and count cycles until its result is visible.
  task automatic send_one(input logic [31:0] x, output int lat);
    check("ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t        vecs[10];
  logic [31:0] bp_ops[6];
  logic [31:0] hold;
  exp_t        m;
  int          lat, idx, base;
  logic        go;

  initial begin
    vecs[0] = '{32'h4049_0FDB, 32'h0000_0003, 1'b1, 1'b0};
    vecs[1] = '{32'hC120_0000, 32'hFFFF_FFF6, 1'b0, 1'b0};
    vecs[2] = '{32'h4F00_0000, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0};
    vecs[6] = '{32'h3F00_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[9] = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0, 1'b0};

    bp_ops = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
               32'h4080_0000, 32'hC0A0_0000, 32'h40C0_0000};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_p_lost", 32'(p_lost), 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    clrn = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vectors: pin the model, then check the DUT and its latency.
    foreach (vecs[i]) begin
      m = model(vecs[i].a);
      check($sformatf("model_d_%0d", i), m.d, vecs[i].d);
      check($sformatf("model_flags_%0d", i), 32'({m.p, m.inv}), 32'({vecs[i].p, vecs[i].inv}));
      send_one(vecs[i].a, lat);
      check($sformatf("latency_%0d", i), 32'(lat), 32'd3);
      check($sformatf("dut_d_%0d", i), d, vecs[i].d);
      check($sformatf("dut_flags_%0d", i), 32'({p_lost, invalid}), 32'({vecs[i].p, vecs[i].inv}));
      @(posedge clk); #1;
    end

    // Back-to-back stream of boundary and random operands.
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      case (i)
        0: a = 32'h3F80_0000;
        1: a = 32'hBF80_0000;
        2: a = 32'hCEFF_FFFF;
        3: a = 32'hFF80_0000;
        4: a = 32'h0080_0000;
        5: a = 32'h4B00_0001;
        6: a = 32'h4B80_0001;
        7: a = 32'h3F7F_FFFF;
        default: a = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 160)), 23'($urandom)};
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: six operands, output stalled for four cycles mid-stream.
    idx  = 0;
    base = n_out;
    hold = '0;
    for (int k = 0; k < 40 && (idx < 6 || sb_q.size() != 0); k++) begin
      out_ready = !(k >= 4 && k < 8);
      in_valid  = (idx < 6);
      a         = (idx < 6) ? bp_ops[idx] : 32'd0;
      #1;
      if (k >= 4 && k < 8) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        if (k == 4) hold = d;
        else check("stall_d_hold", d, hold);
      end
      go = in_valid && in_ready;
      @(posedge clk); #1;
      if (go) idx++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_accepted", 32'(idx), 32'd6);
    check("bp_delivered", 32'(n_out - base), 32'd6);

    // Reset with three results in flight and a simultaneous transfer attempt.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 32'h4120_0000 + 32'(i << 20);
      @(posedge clk); #1;
    end
    clrn     = 1'b0;
    in_valid = 1'b1;
    a        = 32'h4248_0000;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_d", d, 32'd0);
    check("mid_rst_flags", 32'({p_lost, invalid}), 32'd0);
    clrn     = 1'b1;
    in_valid = 1'b0;
    base     = n_out;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_stale_valid", 32'(out_valid), 32'd0);
    end
    check("no_stale_delivered", 32'(n_out - base), 32'd0);
    send_one(32'h4228_0000, lat);   // 42.0
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_d", d, 32'd42);
    @(posedge clk); #1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
